// File: rtl/round_judge.sv
// rtl/round_judge.sv - pairs P1/P2 cards into rounds, scores them and ends the game
// Optional build macro TIE_BREAK_COLOR_EN: equal numbers are decided by the higher color.
module round_judge #(
  parameter int WIN_POINTS = 3,
  parameter int MAX_ROUNDS = 5,
  parameter int SCORE_W    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               card_en,
  input  logic               card_whose,
  input  logic [4:0]         card,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic [SCORE_W-1:0] round_cnt,
  output logic               round_done,
  output logic [1:0]         round_winner,
  output logic               seq_err,
  output logic               finish,
  output logic               game_over,
  output logic [1:0]         game_winner
);

`ifdef TIE_BREAK_COLOR_EN
  localparam bit TIE_EN = 1'b1;
`else
  localparam bit TIE_EN = 1'b0;
`endif

  localparam logic [SCORE_W-1:0] WIN_Q   = SCORE_W'(WIN_POINTS);
  localparam logic [SCORE_W-1:0] LIMIT_Q = SCORE_W'(MAX_ROUNDS);
  localparam logic [1:0] WIN_P1 = 2'b01;
  localparam logic [1:0] WIN_P2 = 2'b10;
  localparam logic [1:0] WIN_NONE = 2'b00;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_P1 = 3'd1,
    WAIT_P2 = 3'd2,
    JUDGE   = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t state, state_nx;

  // number = card[2:0] % 5 + 1, giving 1..5
  function automatic logic [2:0] card_number(input logic [4:0] c);
    logic [2:0] v;
    v = c[2:0];
    card_number = (v >= 3'd5) ? (v - 3'd4) : (v + 3'd1);
  endfunction

  // color = card[4:3] % 3 + 1, giving 1..3
  function automatic logic [1:0] card_color(input logic [4:0] c);
    card_color = (c[4:3] == 2'd3) ? 2'd1 : (c[4:3] + 2'd1);
  endfunction

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    sat_inc = (v == {SCORE_W{1'b1}}) ? v : (v + 1'b1);
  endfunction

  // Held, already-decoded cards of the round in progress
  logic [2:0] num1_q, num2_q;
  logic [1:0] col1_q, col2_q;

  logic               card_ok;
  logic               seq_err_nx;
  logic               p1_wins, p2_wins;
  logic [SCORE_W-1:0] s1_upd, s2_upd, rc_upd;
  logic               game_end;
  logic [1:0]         judge_winner;
  logic [1:0]         final_winner;

  always_comb begin
    card_ok = 1'b0;
    if (card_en) begin
      if (state == WAIT_P1 && card_whose)
        card_ok = 1'b1;
      else if (state == WAIT_P2 && !card_whose)
        card_ok = 1'b1;
    end
  end

  // A card presented together with start is superseded by the restart, not flagged
  assign seq_err_nx = card_en && !start && !card_ok;

  always_comb begin
    p1_wins = (num1_q > num2_q) || (TIE_EN && num1_q == num2_q && col1_q > col2_q);
    p2_wins = (num2_q > num1_q) || (TIE_EN && num1_q == num2_q && col2_q > col1_q);
    s1_upd  = p1_wins ? sat_inc(score1) : score1;
    s2_upd  = p2_wins ? sat_inc(score2) : score2;
    rc_upd  = sat_inc(round_cnt);
    game_end = (s1_upd == WIN_Q) || (s2_upd == WIN_Q) || (rc_upd == LIMIT_Q);
    if (p1_wins)
      judge_winner = WIN_P1;
    else if (p2_wins)
      judge_winner = WIN_P2;
    else
      judge_winner = WIN_NONE;
    if (s1_upd > s2_upd)
      final_winner = WIN_P1;
    else if (s2_upd > s1_upd)
      final_winner = WIN_P2;
    else
      final_winner = WIN_NONE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (start) begin
      state_nx = WAIT_P1;
    end else begin
      case (state)
        IDLE:    state_nx = IDLE;
        WAIT_P1: if (card_ok) state_nx = WAIT_P2;
        WAIT_P2: if (card_ok) state_nx = JUDGE;
        JUDGE:   state_nx = game_end ? DONE : WAIT_P1;
        DONE:    state_nx = DONE;
        default: state_nx = IDLE;
      endcase
    end
  end

  assign game_over = (state == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      score1       <= '0;
      score2       <= '0;
      round_cnt    <= '0;
      round_done   <= 1'b0;
      round_winner <= WIN_NONE;
      seq_err      <= 1'b0;
      finish       <= 1'b0;
      game_winner  <= WIN_NONE;
      num1_q       <= '0;
      num2_q       <= '0;
      col1_q       <= '0;
      col2_q       <= '0;
    end else begin
      round_done <= 1'b0;
      finish     <= 1'b0;
      seq_err    <= seq_err_nx;
      if (start) begin
        score1       <= '0;
        score2       <= '0;
        round_cnt    <= '0;
        round_winner <= WIN_NONE;
        game_winner  <= WIN_NONE;
        num1_q       <= '0;
        num2_q       <= '0;
        col1_q       <= '0;
        col2_q       <= '0;
      end else begin
        case (state)
          WAIT_P1: begin
            if (card_ok) begin
              num1_q <= card_number(card);
              col1_q <= card_color(card);
            end
          end
          WAIT_P2: begin
            if (card_ok) begin
              num2_q <= card_number(card);
              col2_q <= card_color(card);
            end
          end
          JUDGE: begin
            score1       <= s1_upd;
            score2       <= s2_upd;
            round_cnt    <= rc_upd;
            round_winner <= judge_winner;
            round_done   <= 1'b1;
            if (game_end) begin
              finish      <= 1'b1;
              game_winner <= final_winner;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_round_judge.sv
// tb/tb_round_judge.sv - self-checking bench for round_judge against a round-level game model
module tb_round_judge;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       card_en = 1'b0;
  logic       card_whose = 1'b0;
  logic [4:0] card = '0;
  logic [3:0] score1, score2, round_cnt;
  logic       round_done, seq_err, finish, game_over;
  logic [1:0] round_winner, game_winner;

  int n_vec = 0;
  int n_err = 0;

  // Game model: plain integers and the card-ranking rule
  int         m_s1, m_s2, m_rc;
  logic [1:0] m_rw, m_gw;
  bit         m_over;

  round_judge dut (
    .clk(clk), .rst(rst), .start(start), .card_en(card_en), .card_whose(card_whose),
    .card(card), .score1(score1), .score2(score2), .round_cnt(round_cnt),
    .round_done(round_done), .round_winner(round_winner), .seq_err(seq_err),
    .finish(finish), .game_over(game_over), .game_winner(game_winner)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  function automatic int rank(input logic [4:0] c);
    int num, col;
    num = int'(c[2:0]) % 5 + 1;
    col = int'(c[4:3]) % 3 + 1;
`ifdef TIE_BREAK_COLOR_EN
    return num * 10 + col;
`else
    return num * 10 + 0 * col;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_s1 = 0; m_s2 = 0; m_rc = 0;
    m_rw = 2'b00; m_gw = 2'b00; m_over = 1'b0;
  endtask

  task automatic check_all(input string tag);
    check({tag, "_score1"}, 32'(score1), 32'(m_s1));
    check({tag, "_score2"}, 32'(score2), 32'(m_s2));
    check({tag, "_round_cnt"}, 32'(round_cnt), 32'(m_rc));
    check({tag, "_round_winner"}, 32'(round_winner), 32'(m_rw));
    check({tag, "_game_over"}, 32'(game_over), 32'(m_over));
    if (m_over)
      check({tag, "_game_winner"}, 32'(game_winner), 32'(m_gw));
  endtask

  task automatic apply_card(input logic w, input logic [4:0] c);
    card_whose = w;
    card = c;
    card_en = 1'b1;
    tick();
    card_en = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    model_clear();
  endtask

  task automatic stray(input string tag, input logic w, input logic [4:0] c);
    apply_card(w, c);
    check({tag, "_seq_err"}, 32'(seq_err), 32'd1);
  endtask

  task automatic play_round(input string tag, input logic [4:0] c1, input logic [4:0] c2);
    int k1, k2;
    apply_card(1'b1, c1);
    check({tag, "_p1_seq_err"}, 32'(seq_err), 32'd0);
    apply_card(1'b0, c2);
    check({tag, "_p2_seq_err"}, 32'(seq_err), 32'd0);
    check({tag, "_early_done"}, 32'(round_done), 32'd0);
    tick();
    k1 = rank(c1);
    k2 = rank(c2);
    m_rc++;
    if (k1 > k2) begin m_s1++; m_rw = 2'b01; end
    else if (k2 > k1) begin m_s2++; m_rw = 2'b10; end
    else m_rw = 2'b00;
    if (m_s1 == 3 || m_s2 == 3 || m_rc == 5) begin
      m_over = 1'b1;
      m_gw = (m_s1 > m_s2) ? 2'b01 : (m_s2 > m_s1) ? 2'b10 : 2'b00;
    end
    check({tag, "_round_done"}, 32'(round_done), 32'd1);
    check({tag, "_finish"}, 32'(finish), 32'(m_over));
    check_all(tag);
    tick();
    check({tag, "_done_pulse_end"}, 32'(round_done), 32'd0);
    check({tag, "_finish_pulse_end"}, 32'(finish), 32'd0);
  endtask

  initial begin
    model_clear();
    // Reset state
    tick();
    check_all("reset");
    check("reset_round_done", 32'(round_done), 32'd0);
    check("reset_seq_err", 32'(seq_err), 32'd0);
    check("reset_finish", 32'(finish), 32'd0);
    check("reset_game_winner", 32'(game_winner), 32'd0);
    rst = 1'b1;
    tick();

    // Cards before start are rejected; a P1 card stays rejected, so still IDLE
    stray("idle_p2", 1'b0, 5'b00001);
    stray("idle_p1", 1'b1, 5'b00100);

    // Reset asserted mid-WAIT_P2 after one scored round
    do_start();
    play_round("pre", 5'b00100, 5'b00000);
    apply_card(1'b1, 5'b00011);
    rst = 1'b0;
    #1;
    model_clear();
    check_all("midrst");
    check("midrst_seq_err", 32'(seq_err), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    stray("postrst", 1'b1, 5'b00100);

    // Directed rounds
    do_start();
    play_round("t2", 5'b01100, 5'b00010);
    check("t2_score1_const", 32'(score1), 32'd1);
    check("t2_winner_const", 32'(round_winner), 32'd1);
    play_round("t3", 5'b10001, 5'b01001);
`ifdef TIE_BREAK_COLOR_EN
    check("t3_winner_const", 32'(round_winner), 32'd1);
`else
    check("t3_winner_const", 32'(round_winner), 32'd0);
`endif
    check("t3_rc_const", 32'(round_cnt), 32'd2);

    // Wrong player in WAIT_P1, then the P1 card is still accepted
    stray("t4", 1'b0, 5'b00111);
    play_round("t4r", 5'b00100, 5'b00001);

    // P1 keeps winning until the points target ends the game
    while (!m_over)
      play_round("t5", 5'b00100, 5'b00000);
    check("t5_score1_const", 32'(score1), 32'd3);
    check("t5_gw_const", 32'(game_winner), 32'd1);
    stray("t5_done", 1'b1, 5'b00100);
    check("t5_still_over", 32'(game_over), 32'd1);

    // Five draws end the game on the round limit
    do_start();
    for (int r = 0; r < 5; r++)
      play_round("t6", 5'b11110, 5'b11110);
    check("t6_rc_const", 32'(round_cnt), 32'd5);
    check("t6_gw_const", 32'(game_winner), 32'd0);
    check("t6_over_const", 32'(game_over), 32'd1);
    do_start();
    check_all("t6_restart");
    play_round("t6_after", 5'b00000, 5'b00100);

    // start beats a same-cycle card; mid-game restart clears scores
    apply_card(1'b1, 5'b00010);
    start = 1'b1;
    card_whose = 1'b0;
    card = 5'b00100;
    card_en = 1'b1;
    tick();
    start = 1'b0;
    card_en = 1'b0;
    model_clear();
    check_all("prio");
    play_round("prio_r", 5'b00011, 5'b00011);

    // Randomized games
    for (int g = 0; g < 8; g++) begin
      do_start();
      while (!m_over) begin
        if ($urandom_range(3) == 0)
          stray("rnd_stray", 1'b0, 5'($urandom));
        play_round("rnd", 5'($urandom), 5'($urandom));
      end
      stray("rnd_done", 1'($urandom), 5'($urandom));
      check("rnd_over", 32'(game_over), 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
